// File: rtl/mux_bist_pkg.sv
// Shared types, sizing constants and golden model for the
// 2:1 mux built-in self-test controller.
package mux_bist_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;
  localparam int FCNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic logic mux_expect(
    input logic a,
    input logic b,
    input logic c
  );
    return c ? b : a;
  endfunction

endpackage

// File: rtl/mux_bist_settle_cnt.sv
// Loadable down-counter with zero flag; times the settle
// window between presenting a vector and sampling z.
module mux_bist_settle_cnt
  import mux_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_bist_ctrl.sv
// Self-test sequencer: walks all 8 {a,b,c} vectors through a
// 2:1 mux, compares z against the golden model, reports.
module mux_bist_ctrl
  import mux_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              a_out,
  output logic              b_out,
  output logic              c_out,
  input  logic              z_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FCNT_W-1:0] fail_count,
  output logic [IDX_W-1:0]  first_fail_vec,
  output logic              first_fail_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FCNT_W-1:0] fc_q, fc_d;
  logic [IDX_W-1:0]  ffv_q, ffv_d;
  logic              ffok_q, ffok_d;
  logic              pass_q, pass_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic mismatch;

  mux_bist_settle_cnt u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .val_i  (SETTLE_LD),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // The stimulus is the index itself, so it naturally holds
  // the last vector once the run leaves CHECK.
  assign a_out = idx_q[2];
  assign b_out = idx_q[1];
  assign c_out = idx_q[0];

  assign mismatch =
    (z_in != mux_expect(idx_q[2], idx_q[1], idx_q[0]));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_zero) state_d = ST_CHECK;
      ST_CHECK:  state_d = (idx_q == LAST_IDX) ?
                           ST_DONE : ST_DRIVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    cnt_load = (state_q == ST_DRIVE);
    cnt_dec  = (state_q == ST_SETTLE);
  end

  always_comb begin
    idx_d  = idx_q;
    fc_d   = fc_q;
    ffv_d  = ffv_q;
    ffok_d = ffok_q;
    pass_d = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d  = '0;
          fc_d   = '0;
          ffv_d  = '0;
          ffok_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          fc_d = fc_q + FCNT_W'(1);
          if (!ffok_q) begin
            ffv_d  = idx_q;
            ffok_d = 1'b1;
          end
        end
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: pass_d = (fc_q == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      fc_q   <= '0;
      ffv_q  <= '0;
      ffok_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      fc_q   <= fc_d;
      ffv_q  <= ffv_d;
      ffok_q <= ffok_d;
      pass_q <= pass_d;
    end
  end

  assign pass             = pass_q;
  assign fail_count       = fc_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffok_q;

endmodule
